// File: rtl/idecode_cu_issue_pkg.sv
// Shared definitions for the decode/issue stage: widths, special micro-code
// addresses, CU bus layout, opcode constants and the packet record.
package idecode_cu_issue_pkg;

    localparam int OPCODE_W = 6;
    localparam int UADDR_W  = 8;
    localparam int UCNT_W   = 3;
    localparam int PC_W     = 8;
    localparam int INSTR_W  = 32;
    localparam int BUS_W    = 92;

    localparam logic [UADDR_W-1:0] NOP_UADDR = 8'hFF;
    localparam logic [UADDR_W-1:0] ILL_UADDR = 8'hFE;

    // CU bus bit positions
    localparam int BUS_INSTR_LSB = 0;
    localparam int BUS_UADDR_LSB = 32;
    localparam int BUS_UCNT_LSB  = 40;
    localparam int BUS_ZERO_LSB  = 43;
    localparam int BUS_NT_LSB    = 75;
    localparam int BUS_BIA_LSB   = 83;
    localparam int BUS_PRED_BIT  = 91;

    // Opcode map (instr[31:26])
    localparam logic [OPCODE_W-1:0] OP_NOP  = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 6'h01;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_LD   = 6'h03;
    localparam logic [OPCODE_W-1:0] OP_ST   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 6'h05;
    localparam logic [OPCODE_W-1:0] OP_DIV  = 6'h06;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'h10;
    localparam logic [OPCODE_W-1:0] OP_BNE  = 6'h11;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 6'h12;
    localparam logic [OPCODE_W-1:0] OP_CALL = 6'h13;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // Decoded packet as held in head/skid; ill never reaches the bus
    typedef struct packed {
        logic                  ill;
        logic                  pred;
        logic [PC_W-1:0]       bia;
        logic [PC_W-1:0]       nt;
        logic [UCNT_W-1:0]     ucnt;
        logic [UADDR_W-1:0]    uaddr;
        logic [INSTR_W-1:0]    instr;
    } pkt_t;

    function automatic logic is_branch_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_JMP) || (op == OP_CALL);
    endfunction

    function automatic pkt_t bubble_pkt();
        pkt_t p;
        p       = '0;
        p.uaddr = NOP_UADDR;
        return p;
    endfunction

    function automatic logic [BUS_W-1:0] pack_bus(input pkt_t p);
        return {p.pred, p.bia, p.nt, 32'h0, p.ucnt, p.uaddr, p.instr};
    endfunction

endpackage

// File: rtl/idecode_cu_issue_micro_code_map.sv
// Opcode -> micro-code entry point, extra micro-op count and class flags.
module idecode_cu_issue_micro_code_map
    import idecode_cu_issue_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output logic [UADDR_W-1:0]  uaddr,
    output logic [UCNT_W-1:0]   ucnt,
    output logic                is_branch,
    output logic                legal
);

    // Lookup table; anything unlisted goes to the trap routine
    always_comb begin
        uaddr = ILL_UADDR;
        ucnt  = '0;
        legal = 1'b1;
        case (opcode)
            OP_NOP:  begin uaddr = 8'h00; ucnt = 3'd0; end
            OP_ADD:  begin uaddr = 8'h04; ucnt = 3'd0; end
            OP_SUB:  begin uaddr = 8'h05; ucnt = 3'd0; end
            OP_LD:   begin uaddr = 8'h08; ucnt = 3'd1; end
            OP_ST:   begin uaddr = 8'h0C; ucnt = 3'd1; end
            OP_MUL:  begin uaddr = 8'h10; ucnt = 3'd3; end
            OP_DIV:  begin uaddr = 8'h20; ucnt = 3'd7; end
            OP_BEQ:  begin uaddr = 8'h40; ucnt = 3'd1; end
            OP_BNE:  begin uaddr = 8'h42; ucnt = 3'd1; end
            OP_JMP:  begin uaddr = 8'h44; ucnt = 3'd0; end
            OP_CALL: begin uaddr = 8'h48; ucnt = 3'd2; end
            default: begin uaddr = ILL_UADDR; ucnt = '0; legal = 1'b0; end
        endcase
        is_branch = legal & is_branch_op(opcode);
    end

endmodule

// File: rtl/idecode_cu_issue.sv
// Decode/issue stage: decodes at IF accept, buffers up to two packets
// (head = oldest, skid = second) and drives the CU bus from head only.
module idecode_cu_issue
    import idecode_cu_issue_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_pipeline,
    input  logic               if_valid,
    output logic               if_ready,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic [PC_W-1:0]    if_pc,
    input  logic               if_pred_taken,
    input  logic               cu_take,
    output logic [BUS_W-1:0]   idecode_cu_interface,
    output logic               illegal_instr
);

    occ_e                state;
    pkt_t                head_q;
    pkt_t                skid_q;
    pkt_t                dec;
    logic [UADDR_W-1:0]  map_uaddr;
    logic [UCNT_W-1:0]   map_ucnt;
    logic                map_br;
    logic                map_legal;
    logic                accept;

    idecode_cu_issue_micro_code_map u_map (
        .opcode    (if_instr[31:26]),
        .uaddr     (map_uaddr),
        .ucnt      (map_ucnt),
        .is_branch (map_br),
        .legal     (map_legal)
    );

    assign accept = if_valid & if_ready;

    // Build the packet for the instruction IF is presenting
    always_comb begin
        dec       = '0;
        dec.instr = if_instr;
        dec.uaddr = map_uaddr;
        dec.ucnt  = map_ucnt;
        dec.nt    = if_pc + PC_W'(1);
        dec.bia   = if_pc;
        dec.pred  = if_pred_taken & map_br;
        dec.ill   = ~map_legal;
    end

    // Occupancy FSM; head is reloaded with a bubble whenever it drains so the
    // bus can come straight off the register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= OCC_EMPTY;
            head_q   <= bubble_pkt();
            skid_q   <= bubble_pkt();
            if_ready <= 1'b1;
        end else if (flush_pipeline) begin
            state    <= OCC_EMPTY;
            head_q   <= bubble_pkt();
            if_ready <= 1'b1;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (accept) begin
                        state  <= OCC_ONE;
                        head_q <= dec;
                    end
                end
                OCC_ONE: begin
                    if (cu_take && accept) begin
                        head_q <= dec;
                    end else if (cu_take) begin
                        state  <= OCC_EMPTY;
                        head_q <= bubble_pkt();
                    end else if (accept) begin
                        state    <= OCC_TWO;
                        skid_q   <= dec;
                        if_ready <= 1'b0;
                    end
                end
                OCC_TWO: begin
                    if (cu_take) begin
                        state    <= OCC_ONE;
                        head_q   <= skid_q;
                        if_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= OCC_EMPTY;
                    head_q   <= bubble_pkt();
                    if_ready <= 1'b1;
                end
            endcase
        end
    end

    assign idecode_cu_interface = pack_bus(head_q);

    // Trap flag accompanies the cycle the CU actually consumes the packet
    assign illegal_instr = cu_take & ~flush_pipeline & (state != OCC_EMPTY) & head_q.ill;

endmodule

// File: tb/tb_idecode_cu_issue.sv
// Bench for idecode_cu_issue: directed scenarios plus random traffic,
// checked against a queue-based model of the two-deep issue buffer.
module tb_idecode_cu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_pipeline;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [7:0]  if_pc;
    logic        if_pred_taken;
    logic        cu_take;
    logic [91:0] bus;
    logic        illegal_instr;

    int n_chk = 0;
    int n_err = 0;

    // model: each entry is {illegal, bus image}
    logic [92:0] q[$];
    logic [91:0] BUBBLE;
    logic [5:0]  legal_ops[11];

    idecode_cu_issue dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush_pipeline       (flush_pipeline),
        .if_valid             (if_valid),
        .if_ready             (if_ready),
        .if_instr             (if_instr),
        .if_pc                (if_pc),
        .if_pred_taken        (if_pred_taken),
        .cu_take              (cu_take),
        .idecode_cu_interface (bus),
        .illegal_instr        (illegal_instr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [91:0] act, input logic [91:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // reference decode straight from the opcode table and field rules
    function automatic logic [92:0] ref_dec(input logic [31:0] ins, input logic [7:0] pc, input logic pr);
        logic [7:0]  ua;
        int          cnt;
        logic        br;
        logic        ill;
        logic [91:0] b;
        br = 0; ill = 0; cnt = 0;
        case (ins[31:26])
            6'h00: ua = 8'h00;
            6'h01: ua = 8'h04;
            6'h02: ua = 8'h05;
            6'h03: begin ua = 8'h08; cnt = 1; end
            6'h04: begin ua = 8'h0C; cnt = 1; end
            6'h05: begin ua = 8'h10; cnt = 3; end
            6'h06: begin ua = 8'h20; cnt = 7; end
            6'h10: begin ua = 8'h40; cnt = 1; br = 1; end
            6'h11: begin ua = 8'h42; cnt = 1; br = 1; end
            6'h12: begin ua = 8'h44; br = 1; end
            6'h13: begin ua = 8'h48; cnt = 2; br = 1; end
            default: begin ua = 8'hFE; ill = 1; end
        endcase
        b = 92'(ins);
        b = b + (92'(ua) << 32);
        b = b + (92'(cnt) << 40);
        b = b + (92'((int'(pc) + 1) % 256) << 75);
        b = b + (92'(pc) << 83);
        b = b + (92'(pr && br) << 91);
        return {ill, b};
    endfunction

    // one clock: drive, check against model just before the edge, advance model
    task automatic step(input logic fl, input logic v, input logic [31:0] ins,
                        input logic [7:0] pc, input logic pr, input logic tk);
        logic [92:0] hd;
        logic        acc;
        logic        tak;
        flush_pipeline = fl; if_valid = v; if_instr = ins;
        if_pc = pc; if_pred_taken = pr; cu_take = tk;
        #2;
        hd = (q.size() > 0) ? q[0] : {1'b0, BUBBLE};
        chk("bus", bus, hd[91:0]);
        chk("if_ready", 92'(if_ready), 92'(q.size() < 2));
        chk("illegal", 92'(illegal_instr), 92'(tk && !fl && q.size() > 0 && hd[92]));
        acc = v && (q.size() < 2);
        tak = tk && (q.size() > 0);
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (tak) void'(q.pop_front());
            if (acc) q.push_back(ref_dec(ins, pc, pr));
        end
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op);
        return {op, 26'($urandom)};
    endfunction

    initial begin
        logic [31:0] i0, i1, i2;
        logic [5:0]  op;
        BUBBLE = 92'hFF << 32;
        legal_ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                      6'h10, 6'h11, 6'h12, 6'h13};
        rst = 1'b0; flush_pipeline = 0; if_valid = 0; if_instr = 0;
        if_pc = 0; if_pred_taken = 0; cu_take = 0;

        // 1: reset state
        #23;
        chk("rst_bus", bus, BUBBLE);
        chk("rst_ready", 92'(if_ready), 92'd1);
        chk("rst_ill", 92'(illegal_instr), 92'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // 2: 3-count opcode at pc 0x10
        i0 = mk(6'h05);
        step(0, 1, i0, 8'h10, 0, 1);
        chk("t2_cnt", 92'(bus[42:40]), 92'd3);
        chk("t2_bia", 92'(bus[90:83]), 92'h10);
        chk("t2_nt",  92'(bus[82:75]), 92'h11);
        step(0, 0, 0, 0, 0, 1);

        // 3: stall with three offered, then drain in order
        i0 = mk(6'h01); i1 = mk(6'h03); i2 = mk(6'h06);
        step(0, 1, i0, 8'h20, 0, 0);
        step(0, 1, i1, 8'h21, 0, 0);
        step(0, 1, i2, 8'h22, 0, 0);
        chk("t3_ready", 92'(if_ready), 92'd0);
        chk("t3_head", 92'(bus[31:0]), 92'(i0));
        step(0, 1, i2, 8'h22, 0, 1);
        chk("t3_second", 92'(bus[31:0]), 92'(i1));
        step(0, 1, i2, 8'h22, 0, 1);
        chk("t3_third", 92'(bus[31:0]), 92'(i2));
        step(0, 0, 0, 0, 0, 1);

        // 4: pc wrap on a predicted branch, prediction masked on non-branch
        step(0, 1, mk(6'h10), 8'hFF, 1, 1);
        chk("t4_nt_wrap", 92'(bus[82:75]), 92'h00);
        chk("t4_pred", 92'(bus[91]), 92'd1);
        step(0, 1, mk(6'h02), 8'h40, 1, 1);
        chk("t4_pred_nb", 92'(bus[91]), 92'd0);
        step(0, 0, 0, 0, 0, 1);

        // 5: undefined opcode, one trap pulse
        step(0, 1, mk(6'h3A), 8'h50, 0, 0);
        chk("t5_addr", 92'(bus[39:32]), 92'hFE);
        chk("t5_cnt", 92'(bus[42:40]), 92'd0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // 6: flush from TWO with take and valid high
        step(0, 1, mk(6'h3B), 8'h60, 0, 0);
        step(0, 1, mk(6'h04), 8'h61, 0, 0);
        step(1, 1, mk(6'h05), 8'h62, 0, 1);
        chk("t6_bus", bus, BUBBLE);
        chk("t6_ready", 92'(if_ready), 92'd1);
        step(0, 0, 0, 0, 0, 1);

        // async reset mid-operation
        step(0, 1, mk(6'h11), 8'h70, 1, 0);
        step(0, 1, mk(6'h12), 8'h71, 1, 0);
        #2 rst = 1'b0;
        #1 chk("arst_bus", bus, BUBBLE);
        chk("arst_ready", 92'(if_ready), 92'd1);
        q.delete();
        if_valid = 0; cu_take = 0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // random traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 10)];
            else op = 6'($urandom);
            step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, mk(op),
                 8'($urandom), 1'($urandom), $urandom_range(0, 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
